// File: rtl/prog_loader_if.sv
// Download and fetch bundle between the program source / CPU side (master)
// and the instruction-memory loader (slave).
interface prog_loader_if #(
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 256
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic               dl_start;
    logic [ADDR_W-1:0]  dl_base;
    logic [ADDR_W:0]    dl_len;
    logic               dl_abort;
    logic               dl_valid;
    logic [INSTR_W-1:0] dl_data;
    logic               dl_ready;
    logic               dl_busy;
    logic               dl_done;
    logic               dl_err;
    logic [INSTR_W-1:0] dl_checksum;
    logic               cpu_hold;
    logic               fetch_en;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [INSTR_W-1:0] fetch_data;
    logic               fetch_valid;

    modport master (
        output dl_start, dl_base, dl_len, dl_abort, dl_valid, dl_data,
        output fetch_en, fetch_addr,
        input  dl_ready, dl_busy, dl_done, dl_err, dl_checksum, cpu_hold,
        input  fetch_data, fetch_valid
    );

    modport slave (
        input  dl_start, dl_base, dl_len, dl_abort, dl_valid, dl_data,
        input  fetch_en, fetch_addr,
        output dl_ready, dl_busy, dl_done, dl_err, dl_checksum, cpu_hold,
        output fetch_data, fetch_valid
    );
endinterface

// File: rtl/prog_loader.sv
// Instruction-memory loader: streams a program block into RAM with a running
// checksum, holds the CPU until a clean load, then serves 1-cycle fetches.
module prog_loader #(
    parameter  int INSTR_W = 16,
    parameter  int DEPTH   = 256,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    prog_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W:0]    remaining;
    logic [INSTR_W-1:0] checksum;
    logic               done_q;
    logic               done_set;
    logic               fetch_valid_q;
    logic [INSTR_W-1:0] fetch_data_q;
    logic [INSTR_W-1:0] mem [DEPTH];

    logic               start_take;
    logic               beat;
    logic               write_en;
    logic               last_beat;
    logic               range_bad;
    logic               hold;
    logic               addr_ok;
    logic [ADDR_W+1:0]  load_end;

    // End address is formed two bits wider than an address so it can never wrap.
    assign load_end   = {2'b00, bus.dl_base} + {1'b0, bus.dl_len};
    assign range_bad  = load_end > (ADDR_W+2)'(DEPTH);
    assign start_take = bus.dl_start && (state != LOAD);
    assign beat       = (state == LOAD) && bus.dl_valid;
    assign write_en   = beat && !bus.dl_abort;
    assign last_beat  = (remaining == (ADDR_W+1)'(1));
    assign hold       = (state != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_set;
        end
    end

    always_comb begin
        state_nxt = state;
        done_set  = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (bus.dl_start) begin
                    if (bus.dl_len == '0) begin
                        state_nxt = DONE;
                        done_set  = 1'b1;
                    end else if (range_bad) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.dl_abort) begin
                    state_nxt = ERR;
                end else if (beat && last_beat) begin
                    state_nxt = DONE;
                    done_set  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
            checksum  <= '0;
        end else if (start_take) begin
            ptr       <= bus.dl_base;
            remaining <= bus.dl_len;
            checksum  <= '0;
        end else if (write_en) begin
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            checksum  <= checksum + bus.dl_data;
        end
    end

    // RAM contents survive reset so a loaded program is not lost.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[ptr] <= bus.dl_data;
        end
    end

    if ((1 << ADDR_W) > DEPTH) begin : g_partial_range
        assign addr_ok = ({1'b0, bus.fetch_addr} < (ADDR_W+1)'(DEPTH));
    end else begin : g_full_range
        assign addr_ok = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
        end else if (bus.fetch_en && !hold) begin
            fetch_valid_q <= 1'b1;
            fetch_data_q  <= addr_ok ? mem[bus.fetch_addr] : '0;
        end else begin
            fetch_valid_q <= 1'b0;
        end
    end

    assign bus.dl_ready    = (state == LOAD);
    assign bus.dl_busy     = (state == LOAD);
    assign bus.dl_done     = done_q;
    assign bus.dl_err      = (state == ERR);
    assign bus.dl_checksum = checksum;
    assign bus.cpu_hold    = hold;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data_q;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a behavioural model checked every cycle plus
// hand-computed literal checks at key points of each scenario.
module tb_prog_loader;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 256;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prog_loader_if #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

    prog_loader #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Model state: what the loader has promised so far, in plain integers.
    bit m_loading, m_hold, m_err, m_done, m_fvalid, m_fknown;
    int m_ptr, m_left, m_sum, m_fdata, m_addr;
    int m_mem [DEPTH];
    bit m_known [DEPTH];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        else
            checks_passed++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loading = 1'b0;
            m_hold    = 1'b1;
            m_err     = 1'b0;
            m_done    = 1'b0;
            m_sum     = 0;
            m_fvalid  = 1'b0;
            m_fdata   = 0;
            m_fknown  = 1'b1;
        end else begin
            if (bus.fetch_en && !m_hold) begin
                m_fvalid = 1'b1;
                m_addr   = int'(bus.fetch_addr);
                if (m_addr >= DEPTH) begin
                    m_fdata  = 0;
                    m_fknown = 1'b1;
                end else begin
                    m_fdata  = m_mem[m_addr];
                    m_fknown = m_known[m_addr];
                end
            end else begin
                m_fvalid = 1'b0;
            end
            m_done = 1'b0;
            if (!m_loading && bus.dl_start) begin
                m_sum = 0;
                m_err = 1'b0;
                if (bus.dl_len == 0) begin
                    m_hold = 1'b0;
                    m_done = 1'b1;
                end else if (int'(bus.dl_base) + int'(bus.dl_len) > DEPTH) begin
                    m_err  = 1'b1;
                    m_hold = 1'b1;
                end else begin
                    m_loading = 1'b1;
                    m_hold    = 1'b1;
                    m_ptr     = int'(bus.dl_base);
                    m_left    = int'(bus.dl_len);
                end
            end else if (m_loading) begin
                if (bus.dl_abort) begin
                    m_loading = 1'b0;
                    m_err     = 1'b1;
                end else if (bus.dl_valid) begin
                    m_mem[m_ptr]   = int'(bus.dl_data);
                    m_known[m_ptr] = 1'b1;
                    m_sum          = (m_sum + int'(bus.dl_data)) % 65536;
                    m_ptr++;
                    m_left--;
                    if (m_left == 0) begin
                        m_loading = 1'b0;
                        m_hold    = 1'b0;
                        m_done    = 1'b1;
                    end
                end
            end
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        checkOutput("dl_ready",    32'(bus.dl_ready),    32'(m_loading));
        checkOutput("dl_busy",     32'(bus.dl_busy),     32'(m_loading));
        checkOutput("dl_done",     32'(bus.dl_done),     32'(m_done));
        checkOutput("dl_err",      32'(bus.dl_err),      32'(m_err));
        checkOutput("dl_checksum", 32'(bus.dl_checksum), 32'(m_sum));
        checkOutput("cpu_hold",    32'(bus.cpu_hold),    32'(m_hold));
        checkOutput("fetch_valid", 32'(bus.fetch_valid), 32'(m_fvalid));
        if (m_fknown)
            checkOutput("fetch_data", 32'(bus.fetch_data), 32'(m_fdata));
    end

    task automatic applyStimulus(input bit start, input int base, input int len, input bit abort,
                                 input bit valid, input int data, input bit fen, input int faddr);
        bus.dl_start   = start;
        bus.dl_base    = 8'(base);
        bus.dl_len     = 9'(len);
        bus.dl_abort   = abort;
        bus.dl_valid   = valid;
        bus.dl_data    = 16'(data);
        bus.fetch_en   = fen;
        bus.fetch_addr = 8'(faddr);
        @(posedge clk);
        #1;
    endtask

    task automatic startLoad(input int base, input int len);
        applyStimulus(1'b1, base, len, 1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic beatW(input int data);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, data, 1'b0, 0);
    endtask

    task automatic fetchW(input int addr);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, addr);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus.dl_start   = 1'b0;
        bus.dl_base    = '0;
        bus.dl_len     = '0;
        bus.dl_abort   = 1'b0;
        bus.dl_valid   = 1'b0;
        bus.dl_data    = '0;
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst cpu_hold",    32'(bus.cpu_hold),    32'h1);
        checkOutput("rst dl_ready",    32'(bus.dl_ready),    32'h0);
        checkOutput("rst dl_err",      32'(bus.dl_err),      32'h0);
        checkOutput("rst checksum",    32'(bus.dl_checksum), 32'h0);
        checkOutput("rst fetch_valid", 32'(bus.fetch_valid), 32'h0);
        checkOutput("rst fetch_data",  32'(bus.fetch_data),  32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back two-word load at base 10.
        startLoad(10, 2);
        checkOutput("c1 ready", 32'(bus.dl_ready), 32'h1);
        checkOutput("c1 hold",  32'(bus.cpu_hold), 32'h1);
        beatW(16'h2005);
        checkOutput("c1 done early", 32'(bus.dl_done),     32'h0);
        checkOutput("c1 sum1",       32'(bus.dl_checksum), 32'h2005);
        beatW(16'h1FC2);
        checkOutput("c1 done",     32'(bus.dl_done),     32'h1);
        checkOutput("c1 ready lo", 32'(bus.dl_ready),    32'h0);
        checkOutput("c1 checksum", 32'(bus.dl_checksum), 32'h3FC7);
        checkOutput("c1 hold lo",  32'(bus.cpu_hold),    32'h0);
        idle();
        checkOutput("c1 done pulse", 32'(bus.dl_done), 32'h0);

        // Consecutive fetches.
        fetchW(10);
        checkOutput("c5 fvalid0", 32'(bus.fetch_valid), 32'h1);
        checkOutput("c5 fdata10", 32'(bus.fetch_data),  32'h2005);
        fetchW(11);
        checkOutput("c5 fdata11", 32'(bus.fetch_data), 32'h1FC2);
        idle();
        checkOutput("c5 fvalid off", 32'(bus.fetch_valid), 32'h0);
        checkOutput("c5 fdata hold", 32'(bus.fetch_data),  32'h1FC2);

        // Same load with bubbles; a fetch while held is refused.
        startLoad(10, 2);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 10);
        checkOutput("c5 held fvalid", 32'(bus.fetch_valid), 32'h0);
        checkOutput("c5 held fdata",  32'(bus.fetch_data),  32'h1FC2);
        beatW(16'h2005);
        idle();
        checkOutput("c2 bubble done", 32'(bus.dl_done), 32'h0);
        beatW(16'h1FC2);
        checkOutput("c2 done",     32'(bus.dl_done),     32'h1);
        checkOutput("c2 checksum", 32'(bus.dl_checksum), 32'h3FC7);
        fetchW(10);
        checkOutput("c2 fdata10", 32'(bus.fetch_data), 32'h2005);
        fetchW(11);
        checkOutput("c2 fdata11", 32'(bus.fetch_data), 32'h1FC2);

        // Load exactly up to the top of RAM, then overrun attempts.
        startLoad(250, 6);
        for (int i = 0; i < 6; i++) beatW(16'h0A00 + i);
        checkOutput("c3 top done", 32'(bus.dl_done),     32'h1);
        checkOutput("c3 top sum",  32'(bus.dl_checksum), 32'h3C0F);
        startLoad(250, 7);
        checkOutput("c3 err",   32'(bus.dl_err),   32'h1);
        checkOutput("c3 hold",  32'(bus.cpu_hold), 32'h1);
        checkOutput("c3 ready", 32'(bus.dl_ready), 32'h0);
        beatW(16'hDEAD);
        checkOutput("c3 no accept", 32'(bus.dl_checksum), 32'h0);
        startLoad(1, 256);
        checkOutput("c3 err len256", 32'(bus.dl_err), 32'h1);
        startLoad(0, 0);
        checkOutput("c3 len0 done", 32'(bus.dl_done),  32'h1);
        checkOutput("c3 err clear", 32'(bus.dl_err),   32'h0);
        checkOutput("c3 len0 hold", 32'(bus.cpu_hold), 32'h0);
        for (int a = 250; a < 256; a++) fetchW(a);
        checkOutput("c3 ram255", 32'(bus.fetch_data), 32'h0A05);

        // Abort on the third beat of a four-word load.
        startLoad(20, 4);
        for (int i = 0; i < 4; i++) beatW(16'h00A0 + i);
        startLoad(20, 4);
        beatW(16'h1111);
        beatW(16'h2222);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1, 16'h3333, 1'b0, 0);
        checkOutput("c4 err",      32'(bus.dl_err),      32'h1);
        checkOutput("c4 checksum", 32'(bus.dl_checksum), 32'h3333);
        checkOutput("c4 hold",     32'(bus.cpu_hold),    32'h1);
        checkOutput("c4 no done",  32'(bus.dl_done),     32'h0);
        idle();
        checkOutput("c4 no done later", 32'(bus.dl_done), 32'h0);
        startLoad(0, 0);
        fetchW(20);
        checkOutput("c4 ram20", 32'(bus.fetch_data), 32'h1111);
        fetchW(21);
        fetchW(22);
        checkOutput("c4 ram22", 32'(bus.fetch_data), 32'h00A2);
        fetchW(23);
        checkOutput("c4 ram23", 32'(bus.fetch_data), 32'h00A3);

        // Reset in the middle of a load.
        startLoad(40, 3);
        beatW(16'h0BAD);
        rst_n = 1'b0;
        #1;
        checkOutput("c6 ready",    32'(bus.dl_ready),    32'h0);
        checkOutput("c6 busy",     32'(bus.dl_busy),     32'h0);
        checkOutput("c6 hold",     32'(bus.cpu_hold),    32'h1);
        checkOutput("c6 checksum", 32'(bus.dl_checksum), 32'h0);
        checkOutput("c6 fdata",    32'(bus.fetch_data),  32'h0);
        idle();
        idle();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        startLoad(0, 0);
        checkOutput("c6 len0 done", 32'(bus.dl_done),  32'h1);
        checkOutput("c6 len0 hold", 32'(bus.cpu_hold), 32'h0);
        idle();
        checkOutput("c6 done pulse", 32'(bus.dl_done), 32'h0);
        idle();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
